predictor_branch_history: RTL and testbench

//  Upstream of the prediction-check stage. Dynamic branch predictor: a table of 2-bit saturating

---
 rtl/predictor_branch_history_pkg.sv | 20 ++
 rtl/predictor_sat_counter2.sv | 19 +
 rtl/predictor_branch_history.sv | 102 ++++++++++
 tb/tb_predictor_branch_history.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/predictor_branch_history_pkg.sv
// Shared encodings for the branch-history predictor: counter states, branch types, address width.
package predictor_branch_history_pkg;

  localparam int ADDR_W_DEF = 11;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_t;

  typedef enum logic [1:0] {
    BR_NONE  = 2'b00,
    BR_ZERO  = 2'b01,
    BR_NEG   = 2'b10,
    BR_CARRY = 2'b11
  } br_type_t;

endpackage

// File: rtl/predictor_sat_counter2.sv
// Combinational next-state of a 2-bit saturating counter: step up on inc, down otherwise.
module predictor_sat_counter2
  import predictor_branch_history_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       inc,
  output logic [1:0] cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (inc) begin
      if (cnt != CNT_ST) cnt_next = cnt + 2'd1;
    end else begin
      if (cnt != CNT_SNT) cnt_next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/predictor_branch_history.sv
// Dynamic branch predictor: table of 2-bit counters indexed by low PC bits, one-cycle lookup.
// Define PREDICTOR_BYPASS_EN to forward a same-index update into the concurrent lookup.
module predictor_branch_history
  import predictor_branch_history_pkg::*;
#(
  parameter int         ADDR_W   = ADDR_W_DEF,
  parameter int         INDEX_W  = 4,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic [ADDR_W-1:0] fetch_target,
  input  logic [1:0]        fetch_type,
  input  logic              stall,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_result,
  input  logic              flush,
  output logic              pred_valid,
  output logic              branch_taken,
  output logic [ADDR_W-1:0] branch_addr,
  output logic [ADDR_W-1:0] jump_addr,
  output logic [1:0]        branch_type
);

  localparam int ENTRIES = 2 ** INDEX_W;

  logic [1:0]         cnt_table [ENTRIES];
  logic [INDEX_W-1:0] fetch_idx;
  logic [INDEX_W-1:0] upd_idx;
  logic [1:0]         upd_cnt;
  logic [1:0]         upd_cnt_next;
  logic [1:0]         lookup_cnt;
  logic               fetch_accept;

  logic               vld_p1;
  logic               taken_p1;
  logic [ADDR_W-1:0]  baddr_p1;
  logic [ADDR_W-1:0]  jaddr_p1;
  logic [1:0]         btype_p1;

  // Upper PC bits of the update port are not needed: the table has no tags.
  logic unused_upd_hi;
  assign unused_upd_hi = &{1'b0, upd_pc[ADDR_W-1:INDEX_W]};

  assign fetch_idx    = fetch_pc[INDEX_W-1:0];
  assign upd_idx      = upd_pc[INDEX_W-1:0];
  assign upd_cnt      = cnt_table[upd_idx];
  assign fetch_accept = fetch_valid && (fetch_type != BR_NONE);

  predictor_sat_counter2 u_sat (
    .cnt      (upd_cnt),
    .inc      (upd_result),
    .cnt_next (upd_cnt_next)
  );

  always_comb begin
    lookup_cnt = cnt_table[fetch_idx];
`ifdef PREDICTOR_BYPASS_EN
    if (upd_valid && (upd_idx == fetch_idx)) lookup_cnt = upd_cnt_next;
`endif
  end

  // Table update: reset wins, so an update presented during reset is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) cnt_table[i] <= CNT_INIT;
    end else if (upd_valid) begin
      cnt_table[upd_idx] <= upd_cnt_next;
    end
  end

  // Stage p1: prediction output registers; flush outranks stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      taken_p1 <= 1'b0;
      baddr_p1 <= '0;
      jaddr_p1 <= '0;
      btype_p1 <= BR_NONE;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (!stall) begin
      vld_p1 <= fetch_accept;
      if (fetch_accept) begin
        taken_p1 <= lookup_cnt[1];
        baddr_p1 <= fetch_pc + ADDR_W'(1);
        jaddr_p1 <= fetch_target;
        btype_p1 <= fetch_type;
      end
    end
  end

  assign pred_valid   = vld_p1;
  assign branch_taken = taken_p1;
  assign branch_addr  = baddr_p1;
  assign jump_addr    = jaddr_p1;
  assign branch_type  = btype_p1;

endmodule

// File: tb/tb_predictor_branch_history.sv
// Directed self-checking bench for predictor_branch_history (default and PREDICTOR_BYPASS_EN builds).
module tb_predictor_branch_history;

  localparam int ADDR_W = 11;

  logic              clk;
  logic              reset;
  logic              fetch_valid;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] fetch_target;
  logic [1:0]        fetch_type;
  logic              stall;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_result;
  logic              flush;
  logic              pred_valid;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_addr;
  logic [ADDR_W-1:0] jump_addr;
  logic [1:0]        branch_type;

  int compared   = 0;
  int mismatched = 0;

  predictor_branch_history dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_valid  (fetch_valid),
    .fetch_pc     (fetch_pc),
    .fetch_target (fetch_target),
    .fetch_type   (fetch_type),
    .stall        (stall),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_result   (upd_result),
    .flush        (flush),
    .pred_valid   (pred_valid),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .jump_addr    (jump_addr),
    .branch_type  (branch_type)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_fetch(input logic v, input logic [ADDR_W-1:0] pc,
                           input logic [ADDR_W-1:0] tgt, input logic [1:0] typ);
    fetch_valid  = v;
    fetch_pc     = pc;
    fetch_target = tgt;
    fetch_type   = typ;
  endtask

  task automatic set_upd(input logic v, input logic [ADDR_W-1:0] pc, input logic res);
    upd_valid  = v;
    upd_pc     = pc;
    upd_result = res;
  endtask

  task automatic lookup(input logic [ADDR_W-1:0] pc, input logic exp_taken, input string tag);
    set_upd(1'b0, '0, 1'b0);
    set_fetch(1'b1, pc, 11'h000, 2'b01);
    tick();
    check({tag, "_vld"}, 32'(pred_valid), 32'd1);
    check({tag, "_taken"}, 32'(branch_taken), 32'(exp_taken));
  endtask

  logic exp_collide;

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    set_fetch(1'b0, '0, '0, 2'b00);
    set_upd(1'b0, '0, 1'b0);
    tick();
    reset = 1'b0;
    check("rst_vld",   32'(pred_valid),   32'd0);
    check("rst_taken", 32'(branch_taken), 32'd0);
    check("rst_baddr", 32'(branch_addr),  32'd0);
    check("rst_jaddr", 32'(jump_addr),    32'd0);
    check("rst_type",  32'(branch_type),  32'd0);

    // basic lookup on a freshly reset (weak not-taken) entry
    set_fetch(1'b1, 11'h005, 11'h040, 2'b01);
    tick();
    check("t1_vld",   32'(pred_valid),   32'd1);
    check("t1_taken", 32'(branch_taken), 32'd0);
    check("t1_baddr", 32'(branch_addr),  32'h006);
    check("t1_jaddr", 32'(jump_addr),    32'h040);
    check("t1_type",  32'(branch_type),  32'h1);
    set_fetch(1'b0, 11'h123, 11'h456, 2'b11);
    tick();
    check("idle_vld",   32'(pred_valid),  32'd0);
    check("idle_baddr", 32'(branch_addr), 32'h006);
    check("idle_jaddr", 32'(jump_addr),   32'h040);
    set_fetch(1'b1, 11'h123, 11'h456, 2'b00);
    tick();
    check("none_vld",  32'(pred_valid),  32'd0);
    check("none_type", 32'(branch_type), 32'h1);

    // training and saturation at index 5
    set_fetch(1'b0, '0, '0, 2'b00);
    set_upd(1'b1, 11'h005, 1'b1);
    tick();
    tick();
    lookup(11'h005, 1'b1, "t2_st");
    set_upd(1'b1, 11'h005, 1'b1);
    set_fetch(1'b0, '0, '0, 2'b00);
    tick(); tick(); tick();
    set_upd(1'b1, 11'h005, 1'b0);
    tick();
    lookup(11'h005, 1'b1, "t2_wt");
    set_upd(1'b1, 11'h005, 1'b0);
    set_fetch(1'b0, '0, '0, 2'b00);
    tick();
    lookup(11'h005, 1'b0, "t2_wnt");

    // same-index collision at index 3 (counter weak not-taken, update taken)
`ifdef PREDICTOR_BYPASS_EN
    exp_collide = 1'b1;
`else
    exp_collide = 1'b0;
`endif
    set_fetch(1'b1, 11'h003, 11'h077, 2'b10);
    set_upd(1'b1, 11'h003, 1'b1);
    tick();
    check("t3_vld",   32'(pred_valid),   32'd1);
    check("t3_coll",  32'(branch_taken), 32'(exp_collide));
    check("t3_type",  32'(branch_type),  32'h2);
    lookup(11'h003, 1'b1, "t3_after");

    // stall holds outputs while updates still land; flush beats stall
    set_fetch(1'b1, 11'h100, 11'h222, 2'b11);
    tick();
    check("t4_vld",   32'(pred_valid),   32'd1);
    check("t4_taken", 32'(branch_taken), 32'd0);
    check("t4_baddr", 32'(branch_addr),  32'h101);
    stall = 1'b1;
    set_fetch(1'b1, 11'h050, 11'h333, 2'b01);
    set_upd(1'b1, 11'h000, 1'b1);
    tick();
    set_upd(1'b0, '0, 1'b0);
    check("st1_baddr", 32'(branch_addr), 32'h101);
    set_fetch(1'b1, 11'h051, 11'h334, 2'b10);
    tick();
    check("st2_jaddr", 32'(jump_addr),   32'h222);
    set_fetch(1'b0, 11'h052, 11'h335, 2'b00);
    tick();
    check("st3_vld",   32'(pred_valid),  32'd1);
    check("st3_type",  32'(branch_type), 32'h3);
    check("st3_jaddr", 32'(jump_addr),   32'h222);
    flush = 1'b1;
    set_fetch(1'b1, 11'h060, 11'h336, 2'b01);
    tick();
    check("fl_vld",   32'(pred_valid),  32'd0);
    check("fl_baddr", 32'(branch_addr), 32'h101);
    flush = 1'b0;
    stall = 1'b0;
    lookup(11'h200, 1'b1, "st_upd");
    check("st_upd_baddr", 32'(branch_addr), 32'h201);

    // wraparound, plus an update on a different index in the same cycle
    set_fetch(1'b1, 11'h7FF, 11'h000, 2'b01);
    set_upd(1'b1, 11'h013, 1'b0);
    tick();
    check("wrap_baddr", 32'(branch_addr),  32'h000);
    check("wrap_taken", 32'(branch_taken), 32'd0);
    lookup(11'h003, 1'b0, "alias_dn");
    set_fetch(1'b0, '0, '0, 2'b00);
    set_upd(1'b1, 11'h003, 1'b1);
    tick(); tick();
    lookup(11'h013, 1'b1, "alias_up");

    // mid-stream reset discards the concurrent update and clears outputs
    set_fetch(1'b0, '0, '0, 2'b00);
    set_upd(1'b1, 11'h007, 1'b1);
    tick(); tick();
    lookup(11'h007, 1'b1, "pre_rst");
    reset = 1'b1;
    set_upd(1'b1, 11'h007, 1'b1);
    set_fetch(1'b1, 11'h007, 11'h099, 2'b01);
    tick();
    reset = 1'b0;
    check("mr_vld",   32'(pred_valid),   32'd0);
    check("mr_taken", 32'(branch_taken), 32'd0);
    check("mr_baddr", 32'(branch_addr),  32'd0);
    check("mr_jaddr", 32'(jump_addr),    32'd0);
    check("mr_type",  32'(branch_type),  32'd0);
    lookup(11'h007, 1'b0, "mr_i7");
    lookup(11'h013, 1'b0, "mr_i3");
    lookup(11'h000, 1'b0, "mr_i0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
